// File: rtl/shift_sequencer.sv
// shift_sequencer: drives an external SIZE-bit universal shift register
// (hold / shift right / shift left / parallel load) to serialize one word.
// Sequence: IDLE -> LOAD (one cycle, parallel load) -> SHIFT (SIZE bits,
// stall freezes a cycle) -> DONE (one-cycle done pulse) -> IDLE.
// Optional feature macro: SHIFT_SEQUENCER_MSB_FIRST_EN
//   undefined: shift right (mode 01), serial_out = q_out[0], LSB first
//   defined  : shift left  (mode 10), serial_out = q_out[SIZE-1], MSB first
module shift_sequencer #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [SIZE-1:0] data_in,
  input  logic            stall,
  input  logic [SIZE-1:0] q_out,
  output logic            select_1,
  output logic            select_0,
  output logic [SIZE-1:0] load_data,
  output logic            left_serial_in,
  output logic            right_serial_in,
  output logic            serial_out,
  output logic            serial_valid,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

`ifdef SHIFT_SEQUENCER_MSB_FIRST_EN
  localparam logic [1:0] SHIFT_MODE = 2'b10;
`else
  localparam logic [1:0] SHIFT_MODE = 2'b01;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count, count_next;
  logic [SIZE-1:0] word, word_next;
  logic [1:0]      mode;
  logic            out_bit;

  // Only one end of q_out is observed; the remaining bits are intentionally ignored.
  logic unused_q;
  assign unused_q = ^q_out;

`ifdef SHIFT_SEQUENCER_MSB_FIRST_EN
  assign out_bit = q_out[SIZE-1];
`else
  assign out_bit = q_out[0];
`endif

  // Fill bits for both shift directions are tied low.
  assign left_serial_in  = 1'b0;
  assign right_serial_in = 1'b0;

  // State, bit counter and captured word registers; reset forces IDLE immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      word  <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      word  <= word_next;
    end
  end

  // Next-state logic: capture on start in IDLE, step the counter on unstalled shifts.
  always_comb begin
    state_next = state;
    count_next = count;
    word_next  = word;
    case (state)
      IDLE: begin
        if (start) begin
          word_next  = data_in;
          state_next = LOAD;
        end
      end
      LOAD: begin
        count_next = '0;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (!stall) begin
          // Last bit leaves the counter at LAST instead of wrapping.
          if (count == LAST) state_next = DONE;
          else               count_next = count + 1'b1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: register mode, load word, serial bit and status flags per state.
  always_comb begin
    mode         = 2'b00;
    load_data    = '0;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: ;
      LOAD: begin
        mode      = 2'b11;
        load_data = word;
        busy      = 1'b1;
      end
      SHIFT: begin
        busy = 1'b1;
        if (!stall) begin
          mode         = SHIFT_MODE;
          serial_out   = out_bit;
          serial_valid = 1'b1;
        end
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign select_1 = mode[1];
  assign select_0 = mode[0];

endmodule
